// File: rtl/thermo_poller_if.sv
// Bus between thermo_poller and the thermometer/host side; signal suffixes are from the poller's view.
interface thermo_poller_if;
  logic       enable_i;
  logic       clr_i;
  logic [6:0] degree_i;
  logic       busy_i;
  logic       valid_i;
  logic       en_o;
  logic [6:0] temp_o;
  logic       temp_valid_o;
  logic [6:0] min_o;
  logic [6:0] max_o;
  logic       alarm_hi_o;
  logic       alarm_lo_o;
  logic       timeout_o;

  modport slave (
    input  enable_i, clr_i, degree_i, busy_i, valid_i,
    output en_o, temp_o, temp_valid_o, min_o, max_o, alarm_hi_o, alarm_lo_o, timeout_o
  );

  modport master (
    output enable_i, clr_i, degree_i, busy_i, valid_i,
    input  en_o, temp_o, temp_valid_o, min_o, max_o, alarm_hi_o, alarm_lo_o, timeout_o
  );
endinterface

// File: rtl/thermo_poller.sv
// Periodic thermometer poller: triggers conversions, captures clamped temperature, tracks min/max, alarms, timeout.
// Define THERMO_POLLER_HYST_EN to add HYST degrees of hysteresis to both alarm flags.
//
// state        | meaning
// S_IDLE       | polling off or waiting for thermometer to go idle
// S_TRIG       | EN_O high for two clocks
// S_WAIT_VALID | waiting for VALID_I rising edge, bounded by TIMEOUT_CYC
// S_WAIT_DONE  | result taken (or timed out), waiting for BUSY_I low
// S_PERIOD     | POLL_PERIOD idle clocks before next trigger
module thermo_poller #(
  parameter int         POLL_PERIOD = 1000,
  parameter int         TIMEOUT_CYC = 16,
  parameter logic [6:0] ALARM_HIGH  = 7'd85,
  parameter logic [6:0] ALARM_LOW   = 7'd5,
  parameter logic [6:0] HYST        = 7'd3
) (
  input logic            clk_i,
  input logic            rst_n_i,
  thermo_poller_if.slave bus
);

  localparam int CNT_MAX = (POLL_PERIOD > TIMEOUT_CYC) ? POLL_PERIOD : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef THERMO_POLLER_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  // With zero hysteresis the set/clear rules collapse to plain threshold compares.
  localparam int HYST_EFF = HYST_ON ? int'(HYST) : 0;
  localparam int HI_CLR   = int'(ALARM_HIGH) - HYST_EFF;
  localparam int LO_CLR   = int'(ALARM_LOW) + HYST_EFF;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TRIG       = 3'd1,
    S_WAIT_VALID = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_PERIOD     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic            w_cnt_zero;
  logic            r_valid_d;
  logic            w_valid_rise;
  logic            w_capture;
  logic            w_timeout;
  logic            w_en;
  logic [6:0]      w_sample;
  int              w_sample_int;
  logic            w_alarm_hi_nxt;
  logic            w_alarm_lo_nxt;
  logic [6:0]      r_temp;
  logic            r_temp_valid;
  logic [6:0]      r_min;
  logic [6:0]      r_max;
  logic            r_first;
  logic            r_alarm_hi;
  logic            r_alarm_lo;
  logic            r_timeout;

  assign w_cnt_zero   = (r_cnt == '0);
  assign w_valid_rise = bus.valid_i && !r_valid_d;
  assign w_capture    = (r_state == S_WAIT_VALID) && w_valid_rise;
  assign w_timeout    = (r_state == S_WAIT_VALID) && !w_valid_rise && w_cnt_zero;
  assign w_sample     = (bus.degree_i > 7'd100) ? 7'd100 : bus.degree_i;
  assign w_sample_int = int'({25'd0, w_sample});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (bus.enable_i && !bus.busy_i) w_next_state = S_TRIG;
      S_TRIG:       if (w_cnt_zero) w_next_state = S_WAIT_VALID;
      S_WAIT_VALID: if (w_valid_rise || w_cnt_zero) w_next_state = S_WAIT_DONE;
      S_WAIT_DONE:  if (!bus.busy_i) w_next_state = bus.enable_i ? S_PERIOD : S_IDLE;
      S_PERIOD: begin
        if (!bus.enable_i)   w_next_state = S_IDLE;
        else if (w_cnt_zero) w_next_state = S_TRIG;
      end
      default:      w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_en = (r_state == S_TRIG);
  end

  // One down-counter serves all timed states; it is reloaded on every state change.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      case (w_next_state)
        S_TRIG:       r_cnt <= CW'(1);
        S_WAIT_VALID: r_cnt <= CW'(TIMEOUT_CYC - 1);
        S_PERIOD:     r_cnt <= CW'(POLL_PERIOD - 1);
        default:      r_cnt <= '0;
      endcase
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_alarm_hi_nxt = r_alarm_hi;
    if (w_sample >= ALARM_HIGH)    w_alarm_hi_nxt = 1'b1;
    else if (w_sample_int < HI_CLR) w_alarm_hi_nxt = 1'b0;
    w_alarm_lo_nxt = r_alarm_lo;
    if (w_sample <= ALARM_LOW)     w_alarm_lo_nxt = 1'b1;
    else if (w_sample_int > LO_CLR) w_alarm_lo_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid_d    <= 1'b0;
      r_temp       <= '0;
      r_temp_valid <= 1'b0;
      r_min        <= '0;
      r_max        <= '0;
      r_first      <= 1'b1;
      r_alarm_hi   <= 1'b0;
      r_alarm_lo   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_valid_d    <= bus.valid_i;
      r_temp_valid <= w_capture;
      if (w_capture) begin
        r_temp     <= w_sample;
        r_alarm_hi <= w_alarm_hi_nxt;
        r_alarm_lo <= w_alarm_lo_nxt;
        r_first    <= 1'b0;
        // A clear in the capture cycle restarts tracking from this sample.
        if (bus.clr_i || r_first) begin
          r_min <= w_sample;
          r_max <= w_sample;
        end else begin
          if (w_sample < r_min) r_min <= w_sample;
          if (w_sample > r_max) r_max <= w_sample;
        end
      end else if (bus.clr_i) begin
        r_min   <= '0;
        r_max   <= '0;
        r_first <= 1'b1;
      end
      if (w_timeout)      r_timeout <= 1'b1;
      else if (bus.clr_i) r_timeout <= 1'b0;
    end
  end

  assign bus.en_o         = w_en;
  assign bus.temp_o       = r_temp;
  assign bus.temp_valid_o = r_temp_valid;
  assign bus.min_o        = r_min;
  assign bus.max_o        = r_max;
  assign bus.alarm_hi_o   = r_alarm_hi;
  assign bus.alarm_lo_o   = r_alarm_lo;
  assign bus.timeout_o    = r_timeout;

endmodule

// File: tb/tb_thermo_poller.sv
// Self-checking bench for thermo_poller: directed vector table, hand-written corner sequences, randomized conversions.
module tb_thermo_poller;
  localparam int         POLL = 8;
  localparam int         TOC  = 16;
  localparam logic [6:0] AH   = 7'd85;
  localparam logic [6:0] AL   = 7'd5;
  localparam logic [6:0] HY   = 7'd3;
`ifdef THERMO_POLLER_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  thermo_poller_if u_if ();

  thermo_poller #(
    .POLL_PERIOD(POLL), .TIMEOUT_CYC(TOC), .ALARM_HIGH(AH), .ALARM_LOW(AL), .HYST(HY)
  ) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: what the outputs should read after each conversion outcome.
  int m_temp, m_min, m_max;
  bit m_first, m_hi, m_lo, m_to;

  function automatic void model_reset();
    m_temp = 0; m_min = 0; m_max = 0; m_first = 1; m_hi = 0; m_lo = 0; m_to = 0;
  endfunction

  function automatic void model_clear();
    m_min = 0; m_max = 0; m_first = 1; m_to = 0;
  endfunction

  function automatic void model_timeout();
    m_to = 1;
  endfunction

  function automatic void model_capture(input int deg, input bit clr);
    int t;
    if (clr) model_clear();
    t = (deg > 100) ? 100 : deg;
    m_temp = t;
    if (m_first) begin
      m_min = t; m_max = t; m_first = 0;
    end else begin
      if (t < m_min) m_min = t;
      if (t > m_max) m_max = t;
    end
    if (HYST_ON) begin
      if (t >= int'(AH)) m_hi = 1;
      else if (t < int'(AH) - int'(HY)) m_hi = 0;
      if (t <= int'(AL)) m_lo = 1;
      else if (t > int'(AL) + int'(HY)) m_lo = 0;
    end else begin
      m_hi = (t >= int'(AH));
      m_lo = (t <= int'(AL));
    end
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_temp"}, u_if.temp_o, m_temp);
    chk({tag, "_min"}, u_if.min_o, m_min);
    chk({tag, "_max"}, u_if.max_o, m_max);
    chk({tag, "_alarm_hi"}, u_if.alarm_hi_o, m_hi);
    chk({tag, "_alarm_lo"}, u_if.alarm_lo_o, m_lo);
    chk({tag, "_timeout"}, u_if.timeout_o, m_to);
  endtask

  // Plays the thermometer for one conversion. VALID_I first goes high in the dly-th clock after EN_O falls.
  // mode 0: measure poll period; mode 1: drop ENABLE_I in WAIT_VALID; mode 2: drop ENABLE_I in PERIOD.
  task automatic run_conv(input int deg, input int dly, input bit clr_cap, input bit clr_after, input int mode);
    int cyc;
    int en_hi;
    int pulses;
    bit cap;
    cap = (dly <= TOC);
    cyc = 0;
    while (u_if.en_o !== 1'b1 && cyc < POLL + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("trigger_seen", u_if.en_o, 1);
    u_if.busy_i = 1'b1;
    en_hi = 0;
    while (u_if.en_o === 1'b1 && en_hi < 6) begin
      en_hi++;
      @(negedge clk);
    end
    chk("en_width", en_hi, 2);
    if (mode == 1) u_if.enable_i = 1'b0;
    pulses = 0;
    for (int k = 1; k < dly; k++) begin
      @(negedge clk);
      if (u_if.temp_valid_o === 1'b1) pulses++;
    end
    if (!cap) model_timeout();
    u_if.valid_i  = 1'b1;
    u_if.degree_i = 7'(deg);
    u_if.clr_i    = clr_cap;
    @(negedge clk);
    u_if.clr_i = 1'b0;
    if (u_if.temp_valid_o === 1'b1) pulses++;
    if (cap) begin
      model_capture(deg, clr_cap);
      chk("temp_valid_at_capture", u_if.temp_valid_o, 1);
      chk("temp_at_capture", u_if.temp_o, m_temp);
    end else if (clr_cap) begin
      model_clear();
    end
    repeat (2) begin
      @(negedge clk);
      if (u_if.temp_valid_o === 1'b1) pulses++;
    end
    u_if.valid_i = 1'b0;
    @(negedge clk);
    if (u_if.temp_valid_o === 1'b1) pulses++;
    u_if.busy_i = 1'b0;
    chk("temp_valid_pulses", pulses, cap ? 1 : 0);
    chk_model("conv");
    if (mode == 0) begin
      cyc = 0;
      u_if.clr_i = clr_after;
      do begin
        @(negedge clk);
        u_if.clr_i = 1'b0;
        cyc++;
      end while (u_if.en_o !== 1'b1 && cyc < POLL + 10);
      if (clr_after) model_clear();
      chk("poll_period", cyc, POLL + 1);
    end else begin
      if (mode == 2) begin
        repeat (3) @(negedge clk);
        u_if.enable_i = 1'b0;
      end
      en_hi = 0;
      repeat (POLL + 5) begin
        @(negedge clk);
        if (u_if.en_o !== 1'b0) en_hi++;
      end
      chk("no_trigger_when_disabled", en_hi, 0);
      u_if.enable_i = 1'b1;
    end
  endtask

  typedef struct {
    int deg;
    int dly;
    bit clr_cap;
    bit clr_after;
    int e_temp;
    int e_min;
    int e_max;
    bit e_hi;
    bit e_lo;
    bit e_to;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  initial begin
    int cyc;
    int en_hi;
    int pulses;

    vec[0] = '{42,  3,  1'b0, 1'b0, 42,  42,  42,  1'b0,    1'b0, 1'b0};
    vec[1] = '{30,  5,  1'b0, 1'b0, 30,  30,  42,  1'b0,    1'b0, 1'b0};
    vec[2] = '{90,  1,  1'b0, 1'b0, 90,  30,  90,  1'b1,    1'b0, 1'b0};
    vec[3] = '{20,  16, 1'b0, 1'b0, 20,  20,  90,  1'b0,    1'b0, 1'b0};
    vec[4] = '{70,  17, 1'b0, 1'b1, 20,  0,   0,   1'b0,    1'b0, 1'b0};
    vec[5] = '{120, 2,  1'b0, 1'b0, 100, 100, 100, 1'b1,    1'b0, 1'b0};
    vec[6] = '{3,   4,  1'b1, 1'b0, 3,   3,   3,   1'b0,    1'b1, 1'b0};
    vec[7] = '{85,  2,  1'b0, 1'b0, 85,  3,   85,  1'b1,    1'b0, 1'b0};
    vec[8] = '{83,  2,  1'b0, 1'b0, 83,  3,   85,  HYST_ON, 1'b0, 1'b0};
    vec[9] = '{81,  2,  1'b0, 1'b0, 81,  3,   85,  1'b0,    1'b0, 1'b0};

    u_if.enable_i = 1'b0;
    u_if.clr_i    = 1'b0;
    u_if.degree_i = '0;
    u_if.busy_i   = 1'b0;
    u_if.valid_i  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_en", u_if.en_o, 0);
    chk("reset_temp_valid", u_if.temp_valid_o, 0);
    chk_model("reset");
    rst_n = 1'b1;
    @(negedge clk);
    u_if.enable_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_conv(vec[i].deg, vec[i].dly, vec[i].clr_cap, vec[i].clr_after, 0);
      chk($sformatf("vec%0d_temp", i), u_if.temp_o, vec[i].e_temp);
      chk($sformatf("vec%0d_min", i), u_if.min_o, vec[i].e_min);
      chk($sformatf("vec%0d_max", i), u_if.max_o, vec[i].e_max);
      chk($sformatf("vec%0d_alarm_hi", i), u_if.alarm_hi_o, vec[i].e_hi);
      chk($sformatf("vec%0d_alarm_lo", i), u_if.alarm_lo_o, vec[i].e_lo);
      chk($sformatf("vec%0d_timeout", i), u_if.timeout_o, vec[i].e_to);
    end

    run_conv(50, 4, 1'b0, 1'b0, 1);
    run_conv(60, 6, 1'b0, 1'b0, 2);

    // Reset in the middle of WAIT_VALID, then VALID_I edges that must be ignored.
    cyc = 0;
    while (u_if.en_o !== 1'b1 && cyc < POLL + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_seq_trigger_seen", u_if.en_o, 1);
    u_if.busy_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_en", u_if.en_o, 0);
    chk("rst_async_temp_valid", u_if.temp_valid_o, 0);
    chk_model("rst_async");
    u_if.valid_i  = 1'b1;
    u_if.degree_i = 7'd60;
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    en_hi  = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) u_if.valid_i = 1'b0;
      if (k == 3) u_if.valid_i = 1'b1;
      @(negedge clk);
      if (u_if.temp_valid_o === 1'b1) pulses++;
      if (u_if.en_o !== 1'b0) en_hi++;
    end
    chk("rst_no_capture", pulses, 0);
    chk("rst_no_trigger_while_busy", en_hi, 0);
    chk_model("after_rst");
    u_if.valid_i = 1'b0;
    u_if.busy_i  = 1'b0;

    for (int i = 0; i < 25; i++) begin
      run_conv(int'($urandom_range(127)), int'($urandom_range(20, 1)),
               ($urandom_range(7) == 0), ($urandom_range(7) == 0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/thermo_poller.md
THERMO_POLLER -- requirements
Module: thermo_poller

Interface
REQ-001 SHALL have parameter POLL_PERIOD, 1000, idle clocks between end of one conversion and next trigger (>=1).
REQ-002 SHALL have parameter TIMEOUT_CYC, 16, max clocks from EN_O falling to VALID_I rising (>=1).
REQ-003 SHALL have parameter ALARM_HIGH, 7'd85, high-alarm threshold in degrees C.
REQ-004 SHALL have parameter ALARM_LOW, 7'd5, low-alarm threshold in degrees C.
REQ-005 SHALL have parameter HYST, 7'd3, alarm hysteresis in degrees C (used only with THERMO_POLLER_HYST_EN).
REQ-006 One clock; reset is asynchronous and active-low: CLK_I  input  1  clock, all logic on rising edge.
REQ-007 RST_N_I  input  1  asynchronous active-low reset.
REQ-008 ENABLE_I  input  1  level; 1 = periodic polling active.
REQ-009 CLR_I  input  1  single-cycle clear of MIN_O, MAX_O and TIMEOUT_O.
REQ-010 DEGREE_I  input  7  temperature from thermometer, unsigned degrees C.
REQ-011 BUSY_I  input  1  thermometer conversion in progress.
REQ-012 VALID_I  input  1  thermometer result valid (level, held several cycles).
REQ-013 EN_O  output  1  conversion trigger to thermometer, rising edge starts conversion.
REQ-014 TEMP_O  output  7  last captured temperature, clamped to 0..100.
REQ-015 TEMP_VALID_O  output  1  one-cycle pulse when TEMP_O updates.
REQ-016 MIN_O / MAX_O  output  7 each  minimum / maximum captured temperature since reset or CLR_I.
REQ-017 ALARM_HI_O / ALARM_LO_O  output  1 each  over / under temperature flags.
REQ-018 TIMEOUT_O  output  1  sticky; set when a conversion times out.

Function
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT_VALID, WAIT_DONE, PERIOD.
REQ-020 IDLE: ENABLE_I=1 and BUSY_I=0 -> TRIG next cycle; otherwise stay.
REQ-021 TRIG: EN_O=1 for exactly 2 clocks, then EN_O=0 and -> WAIT_VALID; EN_O SHALL be 0 in every other state.
REQ-022 WAIT_VALID: first cycle with VALID_I=1 and VALID_I=0 the previous cycle -> capture DEGREE_I, -> WAIT_DONE.
REQ-023 WAIT_VALID: timeout counter starts at 0 on entry; reaching TIMEOUT_CYC without capture -> set TIMEOUT_O, no capture, -> WAIT_DONE.
REQ-024 WAIT_DONE: BUSY_I=0 -> PERIOD; further VALID_I cycles of the same conversion SHALL NOT re-capture.
REQ-025 PERIOD: count POLL_PERIOD clocks then -> TRIG; ENABLE_I=0 at any cycle -> IDLE (no trigger).
REQ-026 ENABLE_I falling during TRIG/WAIT_VALID/WAIT_DONE SHALL let the conversion complete, then -> IDLE.
REQ-027 Capture: TEMP_O = min(DEGREE_I,100) one clock after VALID_I rising edge; TEMP_VALID_O high that same cycle only.
REQ-028 First capture after reset or CLR_I loads MIN_O and MAX_O with the sample; later captures update by unsigned compare.
REQ-029 CLR_I coincident with capture: clear then capture, so MIN_O = MAX_O = new sample; TIMEOUT_O cleared.
REQ-030 Alarms update only on capture: ALARM_HI_O = TEMP >= ALARM_HIGH; ALARM_LO_O = TEMP <= ALARM_LOW.
REQ-031 Timeout SHALL NOT change TEMP_O, MIN_O, MAX_O or alarms.

Reset
REQ-032 RST_N_I=0 SHALL immediately force state IDLE, EN_O=0, TEMP_O=0, TEMP_VALID_O=0, MIN_O=0, MAX_O=0, alarms=0, TIMEOUT_O=0, counters=0, first-sample flag set.
REQ-033 Reset mid-conversion SHALL abandon it; after release, next trigger waits for BUSY_I=0 in IDLE.

Configuration
REQ-034 Macro THERMO_POLLER_HYST_EN defined: ALARM_HI_O sets at TEMP >= ALARM_HIGH, clears only at TEMP < ALARM_HIGH-HYST; ALARM_LO_O sets at TEMP <= ALARM_LOW, clears only at TEMP > ALARM_LOW+HYST.
REQ-035 Macro undefined: alarms per REQ-030, HYST ignored.

Verification
REQ-036 ENABLE_I=1, model returns DEGREE_I=42 -> EN_O high 2 clocks, TEMP_O=42, one TEMP_VALID_O pulse, MIN_O=MAX_O=42.
REQ-037 Samples 30, 90, 20 -> MIN_O=20, MAX_O=90, ALARM_HI_O=1 after 90, 0 after 20 (macro off).
REQ-038 No VALID_I for 16 clocks after EN_O falls -> TIMEOUT_O=1, TEMP_O unchanged; CLR_I -> TIMEOUT_O=0.
REQ-039 DEGREE_I=120 -> TEMP_O=100, MAX_O=100, ALARM_HI_O=1.
REQ-040 THERMO_POLLER_HYST_EN, samples 85, 83, 81 -> ALARM_HI_O 1, 1, 0.
REQ-041 RST_N_I low during WAIT_VALID -> all outputs 0 same cycle, no capture of subsequent VALID_I.
